// File: rtl/alu_issue.sv
// alu_issue: single-issue R-type stage with a 32x32 register file.
// Each accepted op walks IDLE -> READ -> EXEC -> WB, one state per cycle;
// the ALU itself sits outside and is fed from the operand/op registers.
module alu_issue (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [5:0]  in_funct,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carryout,
    input  logic        ext_wen,
    input  logic [4:0]  ext_waddr,
    input  logic [31:0] ext_wdata,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_ovf,
    output logic        exc_ill
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    // Everything about an op that must survive from accept to writeback.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [2:0] op;
        logic       ill;
        logic       sgn;   // ADD/SUB: overflow traps and blocks the write
    } uop_t;

    state_t      state, state_nx;
    uop_t        uop_dec, uop_q;
    logic [31:0] rf [32];
    logic [31:0] a_q, b_q, res_q;
    logic        ovf_q;
    logic        acc;
    logic        ovf_trap;
    logic        wb_en;

    // alu_zero and alu_carryout are part of the ALU bundle but nothing here
    // depends on them; only the signed-overflow flag matters for trapping.

    assign in_ready = (state == IDLE);
    assign acc      = in_valid && in_ready;
    assign ovf_trap = uop_q.sgn && ovf_q && !uop_q.ill;
    assign wb_en    = (state == WB) && (uop_q.rd != 5'd0) && !uop_q.ill && !ovf_trap;

    // Decode the incoming funct field into op code and illegal/signed flags.
    always_comb begin
        uop_dec     = '0;
        uop_dec.rs  = in_rs;
        uop_dec.rt  = in_rt;
        uop_dec.rd  = in_rd;
        case (in_funct)
            6'b100100: uop_dec.op = 3'b000;
            6'b100101: uop_dec.op = 3'b001;
            6'b100000: begin uop_dec.op = 3'b010; uop_dec.sgn = 1'b1; end
            6'b100001: uop_dec.op = 3'b010;
            6'b100010: begin uop_dec.op = 3'b110; uop_dec.sgn = 1'b1; end
            6'b100011: uop_dec.op = 3'b110;
            6'b101010: uop_dec.op = 3'b111;
            default:   uop_dec.ill = 1'b1;
        endcase
    end

    // State register; reset aborts whatever op is in flight.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state: leave IDLE only on accept, otherwise march one step a cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc) state_nx = READ;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the decoded op at accept.
    always_ff @(posedge clk) begin
        if (!resetn)  uop_q <= '0;
        else if (acc) uop_q <= uop_dec;
    end

    // Operand fetch in READ; sees any write made at the preceding edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state == READ) begin
            a_q <= rf[uop_q.rs];
            b_q <= rf[uop_q.rt];
        end
    end

    // Register the ALU result and overflow flag at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q <= alu_result;
            ovf_q <= alu_overflow;
        end
    end

    // Register file: external writes only in IDLE, result writes in WB.
    // The two are mutually exclusive by state; r0 is never written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if ((state == IDLE) && ext_wen && (ext_waddr != 5'd0)) begin
            rf[ext_waddr] <= ext_wdata;
        end else if (wb_en) begin
            rf[uop_q.rd] <= res_q;
        end
    end

    assign alu_A    = a_q;
    assign alu_B    = b_q;
    assign alu_op   = uop_q.op;
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

    // Writeback/exception outputs are gated to the WB cycle so they idle at 0.
    assign wb_valid = (state == WB);
    assign wb_rd    = wb_valid ? uop_q.rd : 5'd0;
    assign wb_data  = (wb_valid && !uop_q.ill) ? res_q : 32'd0;
    assign exc_ovf  = wb_valid && ovf_trap;
    assign exc_ill  = wb_valid && uop_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; includes a behavioural model of the
// downstream ALU that answers the stage's alu_A/alu_B/alu_op.
module tb_alu_issue;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_BAD  = 6'b000000;

    logic        clk, resetn, in_valid, in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [5:0]  in_funct;
    logic [31:0] alu_A, alu_B, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_overflow, alu_carryout;
    logic        ext_wen;
    logic [4:0]  ext_waddr, dbg_addr, wb_rd;
    logic [31:0] ext_wdata, dbg_data, wb_data;
    logic        wb_valid, exc_ovf, exc_ill;

    int nchk = 0;
    int nerr = 0;

    // values captured by issue()
    logic [2:0]  tr_op;
    logic [31:0] tr_a, tr_b, tr_wd;
    logic [4:0]  tr_rd;
    logic        tr_wv, tr_eo, tr_ei, tr_early;
    logic [7:0]  rdy;

    alu_issue dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
        .ext_wen(ext_wen), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_ovf(exc_ovf), .exc_ill(exc_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ALU: MIPS-style op codes, overflow = signed overflow.
    logic [32:0] sum33, dif33;
    always_comb begin
        sum33        = {1'b0, alu_A} + {1'b0, alu_B};
        dif33        = {1'b0, alu_A} - {1'b0, alu_B};
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        alu_carryout = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_A & alu_B;
            3'b001: alu_result = alu_A | alu_B;
            3'b010: begin
                alu_result   = sum33[31:0];
                alu_carryout = sum33[32];
                alu_overflow = (alu_A[31] == alu_B[31]) && (sum33[31] != alu_A[31]);
            end
            3'b110: begin
                alu_result   = dif33[31:0];
                alu_carryout = dif33[32];
                alu_overflow = (alu_A[31] != alu_B[31]) && (dif33[31] != alu_A[31]);
            end
            3'b111: begin
                alu_result   = {31'd0, $signed(alu_A) < $signed(alu_B)};
                alu_overflow = (alu_A[31] != alu_B[31]) && (dif33[31] != alu_A[31]);
            end
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ext_wen = 1'b1; ext_waddr = a; ext_wdata = d;
        @(posedge clk); #1;
        ext_wen = 1'b0;
    endtask

    task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // One op through all four states. acc_w writes (wa,wd) on the accept edge;
    // exec_w attempts the same write during EXEC.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] f, input bit acc_w, input bit exec_w,
                         input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        chk("idle_wb_valid", wb_valid, 0);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = f;
        if (acc_w) begin ext_wen = 1'b1; ext_waddr = wa; ext_wdata = wd; end
        @(posedge clk); #1;
        in_valid = 1'b0; ext_wen = 1'b0;
        @(negedge clk);                       // READ
        chk("read_ready", in_ready, 0);
        tr_early = wb_valid | exc_ovf | exc_ill;
        @(negedge clk);                       // EXEC
        tr_early = tr_early | wb_valid | exc_ovf | exc_ill;
        tr_op = alu_op; tr_a = alu_A; tr_b = alu_B;
        if (exec_w) begin ext_wen = 1'b1; ext_waddr = wa; ext_wdata = wd; end
        @(posedge clk); #1;
        ext_wen = 1'b0;
        @(negedge clk);                       // WB
        tr_wv = wb_valid; tr_rd = wb_rd; tr_wd = wb_data; tr_eo = exc_ovf; tr_ei = exc_ill;
        chk("no_early_pulse", tr_early, 0);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0;
        ext_wen = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_alu_A", alu_A, 0);
        chk("rst_alu_B", alu_B, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_exc", {exc_ovf, exc_ill}, 0);
        chk("rst_dbg", dbg_data, 0);

        // basic ADD
        ext_write(5'd1, 32'd5);
        ext_write(5'd2, 32'd3);
        issue(5'd1, 5'd2, 5'd3, F_ADD, 0, 0, 5'd0, 32'd0);
        chk("add_op", tr_op, 3'b010);
        chk("add_A", tr_a, 32'd5);
        chk("add_B", tr_b, 32'd3);
        chk("add_wv", tr_wv, 1);
        chk("add_rd", tr_rd, 5'd3);
        chk("add_wd", tr_wd, 32'd8);
        chk("add_exc", {tr_eo, tr_ei}, 0);
        dbg_chk("add_r3", 5'd3, 32'd8);

        // signed overflow traps, unsigned does not
        ext_write(5'd1, 32'h7FFF_FFFF);
        ext_write(5'd2, 32'd1);
        issue(5'd1, 5'd2, 5'd4, F_ADD, 0, 0, 5'd0, 32'd0);
        chk("addovf_wv", tr_wv, 1);
        chk("addovf_exc", tr_eo, 1);
        dbg_chk("addovf_r4", 5'd4, 32'd0);
        issue(5'd1, 5'd2, 5'd4, F_ADDU, 0, 0, 5'd0, 32'd0);
        chk("addu_exc", tr_eo, 0);
        dbg_chk("addu_r4", 5'd4, 32'h8000_0000);

        // SUBU overflow ignored, SUB overflow trapped (r4 = 0x80000000, r2 = 1)
        issue(5'd4, 5'd2, 5'd12, F_SUBU, 0, 0, 5'd0, 32'd0);
        chk("subu_exc", tr_eo, 0);
        dbg_chk("subu_r12", 5'd12, 32'h7FFF_FFFF);
        issue(5'd4, 5'd2, 5'd13, F_SUB, 0, 0, 5'd0, 32'd0);
        chk("subovf_exc", tr_eo, 1);
        chk("subovf_op", tr_op, 3'b110);
        dbg_chk("subovf_r13", 5'd13, 32'd0);

        // SLT / SUB / AND / OR with r1 = -1, r2 = 1, r3 = 8
        ext_write(5'd1, 32'hFFFF_FFFF);
        ext_write(5'd9, 32'h55);
        issue(5'd1, 5'd2, 5'd5, F_SLT, 0, 0, 5'd0, 32'd0);
        chk("slt_op", tr_op, 3'b111);
        dbg_chk("slt_r5", 5'd5, 32'd1);
        issue(5'd1, 5'd2, 5'd6, F_SUB, 0, 0, 5'd0, 32'd0);
        dbg_chk("sub_r6", 5'd6, 32'hFFFF_FFFE);
        issue(5'd2, 5'd1, 5'd9, F_SLT, 0, 0, 5'd0, 32'd0);
        dbg_chk("sltsw_r9", 5'd9, 32'd0);
        issue(5'd1, 5'd3, 5'd10, F_AND, 0, 0, 5'd0, 32'd0);
        chk("and_op", tr_op, 3'b000);
        dbg_chk("and_r10", 5'd10, 32'd8);
        issue(5'd2, 5'd3, 5'd11, F_OR, 0, 0, 5'd0, 32'd0);
        chk("or_op", tr_op, 3'b001);
        dbg_chk("or_r11", 5'd11, 32'd9);

        // illegal funct, and rd = 0
        ext_write(5'd14, 32'h77);
        issue(5'd1, 5'd2, 5'd14, F_BAD, 0, 0, 5'd0, 32'd0);
        chk("ill_wv", tr_wv, 1);
        chk("ill_exc", tr_ei, 1);
        chk("ill_ovf", tr_eo, 0);
        chk("ill_wd", tr_wd, 0);
        dbg_chk("ill_r14", 5'd14, 32'h77);
        issue(5'd1, 5'd1, 5'd0, F_ADD, 0, 0, 5'd0, 32'd0);
        chk("rd0_wv", tr_wv, 1);
        dbg_chk("rd0_r0", 5'd0, 32'd0);

        // external write on the accept edge is seen by READ
        issue(5'd15, 5'd15, 5'd16, F_ADD, 1, 0, 5'd15, 32'd100);
        chk("accw_A", tr_a, 32'd100);
        dbg_chk("accw_r16", 5'd16, 32'd200);

        // back-to-back dependent ops with in_valid held high
        ext_write(5'd1, 32'd10);
        ext_write(5'd2, 32'd20);
        @(negedge clk);
        in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd7; in_funct = F_ADD;
        rdy = '0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            rdy = {rdy[6:0], in_ready};
            if (c == 3) begin
                chk("b2b_wv1", wb_valid, 1);
                chk("b2b_rd1", wb_rd, 5'd7);
                chk("b2b_wd1", wb_data, 32'd30);
            end
            if (c == 7) begin
                chk("b2b_wv2", wb_valid, 1);
                chk("b2b_rd2", wb_rd, 5'd8);
                chk("b2b_wd2", wb_data, 32'd60);
            end
            @(posedge clk); #1;
            if (c == 0) begin in_rs = 5'd7; in_rt = 5'd7; in_rd = 5'd8; end
            if (c == 4) in_valid = 1'b0;
        end
        chk("b2b_ready_pattern", rdy, 8'b1000_1000);
        dbg_chk("b2b_r8", 5'd8, 32'd60);

        // external write during EXEC is ignored
        issue(5'd1, 5'd2, 5'd17, F_ADD, 0, 1, 5'd18, 32'h99);
        dbg_chk("execw_r18", 5'd18, 32'd0);
        dbg_chk("execw_r17", 5'd17, 32'd30);

        // reset during EXEC aborts the op and clears the file
        @(negedge clk);
        in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd19; in_funct = F_ADD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);                       // READ
        @(negedge clk);                       // EXEC
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rstx_wv", wb_valid, 0);
        chk("rstx_ready", in_ready, 1);
        chk("rstx_exc", {exc_ovf, exc_ill}, 0);
        chk("rstx_alu_A", alu_A, 0);
        chk("rstx_alu_op", alu_op, 0);
        @(negedge clk);
        chk("rstx_wv_later", wb_valid, 0);
        dbg_chk("rstx_r1", 5'd1, 32'd0);
        dbg_chk("rstx_r8", 5'd8, 32'd0);
        dbg_chk("rstx_r19", 5'd19, 32'd0);
        dbg_chk("rstx_r16", 5'd16, 32'd0);
        issue(5'd16, 5'd8, 5'd20, F_ADDU, 0, 0, 5'd0, 32'd0);
        chk("rstx_post_wd", tr_wd, 32'd0);
        chk("rstx_post_wv", tr_wv, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
